decade_counter_ctrl: RTL

DECADE_COUNTER_CTRL -- requirements
Module: decade_counter_ctrl

---
 rtl/decade_ctrl_pkg.sv | 30 +++
 rtl/bcd_digit.sv | 57 +++++
 rtl/decade_counter_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/decade_ctrl_pkg.sv
// Shared definitions for the decade counter controller.
// Holds the controller state enum, the BCD digit width and the largest legal
// digit value, plus a one-digit BCD step helper used by both the digit cell
// (to update its register) and the top (to predict the next count for the
// limit compare).
package decade_ctrl_pkg;

    localparam int unsigned DigitWidth = 4;
    localparam logic [DigitWidth-1:0] DigitMax = 4'd9;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    // One BCD step of a single digit: up wraps 9->0, down wraps 0->9.
    function automatic logic [DigitWidth-1:0] bcd_step(input logic [DigitWidth-1:0] v,
                                                       input logic                  down);
        logic [DigitWidth-1:0] r;
        if (down) begin
            r = (v == '0) ? DigitMax : v - 4'd1;
        end else begin
            r = (v >= DigitMax) ? '0 : v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single mod-10 (BCD) digit cell for a ripple-carry decade counter.
// Optional feature macro: DECADE_DOWN_COUNT_EN (adds dir input and borrow output).
// Ports:
//   clk       - clock, register updates on rising edge
//   en        - count enable; the digit steps only when en and ci are both high
//   ci        - carry-in (borrow-in when counting down) from the lower digit
//   load      - synchronous load, has priority over counting
//   load_data - value to load; anything above 9 is stored as 9
//   dir       - (macro only) 1 = count down
//   borrow    - (macro only) high when ci is set and the digit is at 0
//   value     - current digit value
//   co        - high when ci is set and the digit is at 9
module bcd_digit
    import decade_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  en,
    input  logic                  ci,
    input  logic                  load,
    input  logic [DigitWidth-1:0] load_data,
`ifdef DECADE_DOWN_COUNT_EN
    input  logic                  dir,
    output logic                  borrow,
`endif
    output logic [DigitWidth-1:0] value,
    output logic                  co
);

    logic [DigitWidth-1:0] value_q, value_d;
    logic                  down;

`ifdef DECADE_DOWN_COUNT_EN
    assign down   = dir;
    assign borrow = ci & (value_q == '0);
`else
    assign down   = 1'b0;
`endif

    // Carry/borrow are combinational on ci so the chain reflects what a tick would do.
    assign co    = ci & (value_q == DigitMax);
    assign value = value_q;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = (load_data > DigitMax) ? DigitMax : load_data;
        end else if (en && ci) begin
            value_d = bcd_step(value_q, down);
        end
    end

    // Cleared through the load path by the controller.
    always_ff @(posedge clk) begin
        value_q <= value_d;
    end

endmodule

// File: rtl/decade_counter_ctrl.sv
// Decade (BCD) counter controller: NUM_DIGITS cascaded bcd_digit cells plus a
// run-control FSM (IDLE/RUN/PAUSE/DONE) with preset, terminal limit and wrap pulse.
// Optional feature macro: DECADE_DOWN_COUNT_EN (adds dir input; dir=1 counts down).
// Ports:
//   clk      - clock
//   clear    - synchronous active-high reset (count=0, IDLE, flags low)
//   start    - begin/resume counting; from DONE also zeroes the count
//   stop     - pause counting while in RUN
//   load     - preset count from load_val (ignored in RUN), goes to IDLE
//   load_val - BCD preset, digit 0 in bits [3:0]
//   limit    - BCD terminal value; a tick reaching it in RUN moves to DONE
//   tick     - count strobe, one step per high cycle in RUN
//   dir      - (macro only) count direction, 1 = down
//   count    - current BCD count
//   running  - high in RUN
//   done     - high in DONE
//   wrap     - one-cycle pulse on all-9s <-> all-0s rollover
module decade_counter_ctrl
    import decade_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                             clk,
    input  logic                             clear,
    input  logic                             start,
    input  logic                             stop,
    input  logic                             load,
    input  logic [DigitWidth*NUM_DIGITS-1:0] load_val,
    input  logic [DigitWidth*NUM_DIGITS-1:0] limit,
    input  logic                             tick,
`ifdef DECADE_DOWN_COUNT_EN
    input  logic                             dir,
`endif
    output logic [DigitWidth*NUM_DIGITS-1:0] count,
    output logic                             running,
    output logic                             done,
    output logic                             wrap
);

    state_e state_q, state_d;
    logic   wrap_q, wrap_d;

    logic                             down;
    logic [NUM_DIGITS:0]              chain;
    logic [DigitWidth*NUM_DIGITS-1:0] next_count;
    logic                             digit_en;
    logic                             digit_load;
    logic [DigitWidth*NUM_DIGITS-1:0] digit_load_data;

`ifdef DECADE_DOWN_COUNT_EN
    assign down = dir;
`else
    assign down = 1'b0;
`endif

    assign chain[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic co_up;
`ifdef DECADE_DOWN_COUNT_EN
        logic co_dn;
`endif
        bcd_digit u_digit (
            .clk       (clk),
            .en        (digit_en),
            .ci        (chain[i]),
            .load      (digit_load),
            .load_data (digit_load_data[i*DigitWidth +: DigitWidth]),
`ifdef DECADE_DOWN_COUNT_EN
            .dir       (dir),
            .borrow    (co_dn),
`endif
            .value     (count[i*DigitWidth +: DigitWidth]),
            .co        (co_up)
        );
`ifdef DECADE_DOWN_COUNT_EN
        assign chain[i+1] = dir ? co_dn : co_up;
`else
        assign chain[i+1] = co_up;
`endif
    end

    // Count the digits will hold after a tick; needed to flag DONE on the same edge.
    always_comb begin
        next_count = count;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (chain[i]) begin
                next_count[i*DigitWidth +: DigitWidth] =
                    bcd_step(count[i*DigitWidth +: DigitWidth], down);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        wrap_d          = 1'b0;
        digit_en        = 1'b0;
        digit_load      = 1'b0;
        digit_load_data = '0;
        if (clear) begin
            state_d    = StIdle;
            digit_load = 1'b1;
        end else if (load && (state_q != StRun)) begin
            state_d         = StIdle;
            digit_load      = 1'b1;
            digit_load_data = load_val;
        end else begin
            unique case (state_q)
                StIdle, StPause: begin
                    if (start && !stop) state_d = StRun;
                end
                StRun: begin
                    if (stop) begin
                        state_d = StPause;
                    end else if (tick) begin
                        digit_en = 1'b1;
                        // Carry out of the top digit means a full rollover.
                        wrap_d   = chain[NUM_DIGITS];
                        // Digits never exceed 9, so an illegal limit cannot match.
                        if (next_count == limit) state_d = StDone;
                    end
                end
                StDone: begin
                    if (start && !stop) begin
                        state_d    = StRun;
                        digit_load = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= StIdle;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wrap_q  <= wrap_d;
        end
    end

    assign running = (state_q == StRun);
    assign done    = (state_q == StDone);
    assign wrap    = wrap_q;

endmodule
